// File: rtl/deserializer_32_sr_if.sv
// Serial link receive bundle: serial input side plus the parallel word side.
// The slave modport is the deserializer's view; master is the link/consumer view.
interface deserializer_32_sr_if #(
    parameter int WIDTH = 32
) ();
    logic             sync;
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             resync_err;

    modport slave (
        input  sync,
        input  data_in,
        output data_out,
        output data_valid,
        output busy,
        output resync_err
    );

    modport master (
        output sync,
        output data_in,
        input  data_out,
        input  data_valid,
        input  busy,
        input  resync_err
    );
endinterface

// File: rtl/deserializer_32_sr.sv
// MSB-first serial-to-parallel receiver framed by a sync strobe on the MSB.
// Optional frame/error counters are enabled with the DESER_FRAME_CNT_EN macro.
//
// state | meaning
// IDLE  | waiting for sync; data_in ignored
// SHIFT | frame partially received; bit_cnt bits already captured
module deserializer_32_sr #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    deserializer_32_sr_if.slave       bus
`ifdef DESER_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt,
    output logic [7:0]                err_cnt
`endif
);

    localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int                SR_W  = WIDTH - 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              resync_err_q, resync_err_d;

`ifdef DESER_FRAME_CNT_EN
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            resync_err_q <= 1'b0;
`ifdef DESER_FRAME_CNT_EN
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            resync_err_q <= resync_err_d;
`ifdef DESER_FRAME_CNT_EN
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    // sync always wins, even on the final bit, so a late strobe restarts the frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sync) state_d = SHIFT;
            end
            SHIFT: begin
                if (bus.sync)                state_d = SHIFT;
                else if (bit_cnt_q == LAST)  state_d = IDLE;
                else                         state_d = SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        resync_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.sync) begin
                    shift_d    = '0;
                    shift_d[0] = bus.data_in;
                    bit_cnt_d  = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (bus.sync) begin
                    shift_d      = '0;
                    shift_d[0]   = bus.data_in;
                    bit_cnt_d    = CNT_W'(1);
                    resync_err_d = 1'b1;
                end else if (bit_cnt_q == LAST) begin
                    data_out_d   = {shift_q, bus.data_in};
                    data_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = bus.data_in;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase
    end

`ifdef DESER_FRAME_CNT_EN
    // Counters step on the same edge that raises the matching pulse
    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, data_valid_d};
        err_cnt_d   = err_cnt_q + {7'd0, resync_err_d};
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.resync_err = resync_err_q;

endmodule

// File: tb/tb_deserializer_32_sr.sv
// Directed bench for deserializer_32_sr: framing, back-to-back, resync, reset, idle noise.
module tb_deserializer_32_sr;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    bit   saw_valid;
    int   valid_pulses;

    deserializer_32_sr_if #(.WIDTH(32)) bus ();

`ifdef DESER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    deserializer_32_sr #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef DESER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic step(input logic s, input logic d);
        bus.sync    = s;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (bus.data_valid === 1'b1) begin
            saw_valid    = 1'b1;
            valid_pulses = valid_pulses + 1;
        end
    endtask

    task automatic drive_bits(input logic [31:0] w, input int from, input int to,
                              input logic sync_first);
        for (int i = from; i <= to; i++)
            step(sync_first && (i == from), w[31-i]);
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        bus.sync    = 1'b0;
        bus.data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data_out got %h want %h", bus.data_out, 32'h0); end
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.data_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.resync_err !== 1'b0) begin miscompares++; $display("FAIL reset_resync_err got %b want 0", bus.resync_err); end
        reset_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_single;
        logic [31:0] w;
        w = 32'hA5A5F00F;
        saw_valid = 1'b0;
        for (int i = 0; i < 31; i++) begin
            step(i == 0, w[31-i]);
            vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy bit %0d got %b want 1", i, bus.busy); end
            vectors++; if (bus.resync_err !== 1'b0) begin miscompares++; $display("FAIL single_resync bit %0d got %b want 0", i, bus.resync_err); end
        end
        vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", saw_valid); end
        step(1'b0, w[0]);
        vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", bus.data_valid); end
        vectors++; if (bus.data_out !== w) begin miscompares++; $display("FAIL single_data got %h want %h", bus.data_out, w); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got %b want 0", bus.busy); end
        step(1'b0, 1'b1);
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_width got %b want 0", bus.data_valid); end
        vectors++; if (bus.data_out !== w) begin miscompares++; $display("FAIL single_hold got %h want %h", bus.data_out, w); end
    endtask

    task automatic test_back_to_back;
        drive_bits(32'h00000001, 0, 31, 1'b1);
        vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1 got %b want 1", bus.data_valid); end
        vectors++; if (bus.data_out !== 32'h00000001) begin miscompares++; $display("FAIL b2b_data1 got %h want %h", bus.data_out, 32'h00000001); end
        step(1'b1, 1'b1);
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_gap got %b want 0", bus.data_valid); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
        vectors++; if (bus.resync_err !== 1'b0) begin miscompares++; $display("FAIL b2b_resync got %b want 0", bus.resync_err); end
        drive_bits(32'h80000000, 1, 31, 1'b0);
        vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2 got %b want 1", bus.data_valid); end
        vectors++; if (bus.data_out !== 32'h80000000) begin miscompares++; $display("FAIL b2b_data2 got %h want %h", bus.data_out, 32'h80000000); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_resync;
        int errs;
        valid_pulses = 0;
        errs = 0;
        drive_bits(32'h12345678, 0, 9, 1'b1);
        step(1'b1, 1'b1);
        vectors++; if (bus.resync_err !== 1'b1) begin miscompares++; $display("FAIL resync_pulse got %b want 1", bus.resync_err); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL resync_busy got %b want 1", bus.busy); end
        vectors++; if (bus.data_out !== 32'h80000000) begin miscompares++; $display("FAIL resync_hold got %h want %h", bus.data_out, 32'h80000000); end
        for (int i = 1; i < 31; i++) begin
            step(1'b0, 1'b1);
            if (bus.resync_err === 1'b1) errs++;
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL resync_extra_pulses got %0d want 0", errs); end
        vectors++; if (valid_pulses !== 0) begin miscompares++; $display("FAIL resync_aborted_valid got %0d want 0", valid_pulses); end
        vectors++; if (bus.data_out !== 32'h80000000) begin miscompares++; $display("FAIL resync_hold_late got %h want %h", bus.data_out, 32'h80000000); end
        step(1'b0, 1'b1);
        vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL resync_valid got %b want 1", bus.data_valid); end
        vectors++; if (bus.data_out !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL resync_data got %h want %h", bus.data_out, 32'hFFFFFFFF); end
        step(1'b0, 1'b0);
`ifdef DESER_FRAME_CNT_EN
        vectors++; if (frame_cnt !== 16'd4) begin miscompares++; $display("FAIL frame_cnt got %0d want 4", frame_cnt); end
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL err_cnt got %0d want 1", err_cnt); end
`endif
    endtask

    task automatic test_reset_midframe;
        valid_pulses = 0;
        drive_bits(32'hCAFEF00D, 0, 19, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL midrst_data got %h want %h", bus.data_out, 32'h0); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.data_valid); end
`ifdef DESER_FRAME_CNT_EN
        vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
`endif
        drive_bits(32'hFFFFFFFF, 20, 31, 1'b0);
        vectors++; if (valid_pulses !== 0) begin miscompares++; $display("FAIL midrst_no_valid got %0d want 0", valid_pulses); end
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        drive_bits(32'hDEADBEEF, 0, 31, 1'b1);
        vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_new_valid got %b want 1", bus.data_valid); end
        vectors++; if (bus.data_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL midrst_new_data got %h want %h", bus.data_out, 32'hDEADBEEF); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_idle_noise;
        int bad_valid, bad_busy, bad_data;
        bad_valid = 0; bad_busy = 0; bad_data = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            if (bus.data_valid !== 1'b0) bad_valid++;
            if (bus.busy !== 1'b0) bad_busy++;
            if (bus.data_out !== 32'hDEADBEEF) bad_data++;
        end
        vectors++; if (bad_valid !== 0) begin miscompares++; $display("FAIL idle_valid cycles %0d want 0", bad_valid); end
        vectors++; if (bad_busy !== 0) begin miscompares++; $display("FAIL idle_busy cycles %0d want 0", bad_busy); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL idle_data_changed cycles %0d want 0", bad_data); end
    endtask

    task automatic test_last_bit_resync;
        valid_pulses = 0;
        drive_bits(32'h0F0F0F0F, 0, 30, 1'b1);
        step(1'b1, 1'b0);
        vectors++; if (bus.resync_err !== 1'b1) begin miscompares++; $display("FAIL lastbit_resync got %b want 1", bus.resync_err); end
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL lastbit_valid got %b want 0", bus.data_valid); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL lastbit_busy got %b want 1", bus.busy); end
        vectors++; if (bus.data_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lastbit_hold got %h want %h", bus.data_out, 32'hDEADBEEF); end
        drive_bits(32'h33333333, 1, 31, 1'b0);
        vectors++; if (valid_pulses !== 1) begin miscompares++; $display("FAIL lastbit_pulses got %0d want 1", valid_pulses); end
        vectors++; if (bus.data_out !== 32'h33333333) begin miscompares++; $display("FAIL lastbit_data got %h want %h", bus.data_out, 32'h33333333); end
        step(1'b0, 1'b0);
`ifdef DESER_FRAME_CNT_EN
        vectors++; if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL end_frame_cnt got %0d want 2", frame_cnt); end
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL end_err_cnt got %0d want 1", err_cnt); end
`endif
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        saw_valid    = 1'b0;
        valid_pulses = 0;
        reset_n      = 1'b0;
        bus.sync     = 1'b0;
        bus.data_in  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_resync();
        test_reset_midframe();
        test_idle_noise();
        test_last_bit_resync();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
